// File: rtl/md_unit.sv
// ---------------------------------------------------------------------------
// md_unit
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// It sits in the execute stage directly after the register file. It runs
// MULT, MULTU, DIV and DIVU over WIDTH iteration cycles plus one fix-up
// cycle. MTHI and MTLO write HI or LO in a single cycle.
//
// Ports:
//   clk    - clock, all state changes on the rising edge
//   rst    - synchronous active-high reset; aborts any operation in flight
//   start  - one-cycle request, only looked at while busy is low
//   op     - 0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO 6/7=no-op
//   a, b   - rs / rt operands from the register file
//   busy   - high while a multiply/divide is iterating or fixing up
//   done   - one-cycle pulse in the cycle HI/LO show a new MULT*/DIV* result
//   hi, lo - HI / LO registers
// ---------------------------------------------------------------------------
module md_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    localparam logic [5:0] LAST_STEP = 6'(WIDTH - 1);

    state_t state;
    state_t state_next;

    logic [5:0]       count;

    // Captured operation context
    logic             is_div;
    logic             div_zero;
    logic             neg_lo;
    logic             neg_hi;
    logic [WIDTH-1:0] a_saved;

    // Shared datapath registers.
    // Multiply: opnd = multiplicand, {acc_hi, acc_lo} = partial product,
    //           with the multiplier being shifted out of acc_lo.
    // Divide:   opnd = divisor, acc_hi = partial remainder,
    //           acc_lo = dividend shifting out / quotient shifting in.
    logic [WIDTH:0]   opnd;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;

    // Request decode
    logic             idle;
    logic             accept;
    logic             write_hi;
    logic             write_lo;
    logic             signed_req;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    // Iteration step results
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic             div_fits;

    // Fix-up results
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fixed;
    logic [WIDTH-1:0]   quo_fixed;
    logic [WIDTH-1:0]   rem_fixed;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    // The top bit of the trial difference is never needed. When the
    // subtraction is kept, the remainder is known to be below the divisor.
    logic unused_bits;
    assign unused_bits = div_diff[WIDTH];

    // Decode of a request. Only op codes 0..3 start the iterative engine.
    // Bit 0 clear within that range means a signed operation.
    assign idle       = (state == IDLE);
    assign accept     = idle && start && (op[2] == 1'b0);
    assign write_hi   = idle && start && (op == 3'd4);
    assign write_lo   = idle && start && (op == 3'd5);
    assign signed_req = (op[0] == 1'b0);
    assign a_neg      = signed_req && a[WIDTH-1];
    assign b_neg      = signed_req && b[WIDTH-1];
    assign a_mag      = a_neg ? (~a + 1'b1) : a;
    assign b_mag      = b_neg ? (~b + 1'b1) : b;

    // One shift-add multiply step. The multiplicand is added when the
    // current multiplier LSB is set, then the whole product shifts right.
    assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? opnd : '0);

    // One restoring divide step. The next dividend bit shifts into the
    // remainder, then the divisor is subtracted if it fits.
    assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
    assign div_diff  = div_shift - opnd;
    assign div_fits  = (div_shift >= opnd);

    // Sign correction applied in FIX. A signed product is negated when the
    // operand signs differ. The quotient follows the same rule. The remainder
    // takes the dividend's sign. A divide by zero overrides everything.
    always_comb begin
        prod       = {acc_hi, acc_lo};
        prod_fixed = neg_lo ? (~prod + 1'b1) : prod;
        quo_fixed  = neg_lo ? (~acc_lo + 1'b1) : acc_lo;
        rem_fixed  = neg_hi ? (~acc_hi + 1'b1) : acc_hi;
        fix_hi     = prod_fixed[2*WIDTH-1:WIDTH];
        fix_lo     = prod_fixed[WIDTH-1:0];
        if (is_div) begin
            if (div_zero) begin
                fix_hi = a_saved;
                fix_lo = '1;
            end else begin
                fix_hi = rem_fixed;
                fix_lo = quo_fixed;
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and busy. The engine is busy for the CALC and FIX cycles.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (count == LAST_STEP) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                busy       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Iteration counter. It restarts at every accepted operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (accept) begin
            count <= '0;
        end else if (state == CALC) begin
            count <= count + 6'd1;
        end else begin
            count <= '0;
        end
    end

    // Operand capture and the per-cycle multiply/divide step. Operands are
    // reduced to magnitudes at accept, so the engine itself is purely unsigned.
    always_ff @(posedge clk) begin
        if (rst) begin
            is_div   <= 1'b0;
            div_zero <= 1'b0;
            neg_lo   <= 1'b0;
            neg_hi   <= 1'b0;
            a_saved  <= '0;
            opnd     <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
        end else if (accept) begin
            is_div   <= op[1];
            div_zero <= (b == '0);
            neg_lo   <= a_neg ^ b_neg;
            neg_hi   <= op[1] ? a_neg : (a_neg ^ b_neg);
            a_saved  <= a;
            opnd     <= {1'b0, b_mag};
            acc_hi   <= '0;
            acc_lo   <= a_mag;
        end else if (state == CALC) begin
            if (is_div) begin
                acc_hi <= div_fits ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
                acc_lo <= {acc_lo[WIDTH-2:0], div_fits};
            end else begin
                acc_hi <= mul_sum[WIDTH:1];
                acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
            end
        end
    end

    // Architectural HI/LO. They change only on MTHI/MTLO or at the end of FIX.
    // Old values therefore stay visible while an operation iterates.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi <= '0;
            lo <= '0;
        end else if (state == FIX) begin
            hi <= fix_hi;
            lo <= fix_lo;
        end else if (write_hi) begin
            hi <= a;
        end else if (write_lo) begin
            lo <= a;
        end
    end

    // Completion pulse. It lines up with the first cycle that shows the new HI/LO.
    always_ff @(posedge clk) begin
        if (rst) begin
            done <= 1'b0;
        end else begin
            done <= (state == FIX);
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// ---------------------------------------------------------------------------
// tb_md_unit
// Directed self-checking bench for md_unit (WIDTH=32). Each scenario task
// drives its own stimulus and compares HI/LO/busy/done against hand-computed
// values.
// ---------------------------------------------------------------------------
module tb_md_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks;
    int fails;

    md_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    // Free-running clock, 10 time-unit period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one cycle. Land 1 unit after the rising edge, where outputs are stable.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request in the current cycle (cycle 0) and return in cycle 1.
    // The operands are then scrambled to show they were captured at accept.
    task automatic issue(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb);
        start = 1'b1;
        op    = o;
        a     = va;
        b     = vb;
        step();
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
    endtask

    // Step until done is seen, with a bounded budget. Report the cycle index,
    // counted from the issuing cycle.
    task automatic wait_done(input int first, output int cyc);
        cyc = first;
        while (!done && cyc < 100) begin
            step();
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        op    = 3'd0;
        a     = '0;
        b     = '0;
        step();
        rst = 1'b0;
        checks++; if (hi !== 32'h0)   begin fails++; $display("[TB] FAIL reset_hi got %h want %h", hi, 32'h0); end
        checks++; if (lo !== 32'h0)   begin fails++; $display("[TB] FAIL reset_lo got %h want %h", lo, 32'h0); end
        checks++; if (busy !== 1'b0)  begin fails++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0)  begin fails++; $display("[TB] FAIL reset_done got %b want 0", done); end
    endtask

    task automatic test_mt();
        issue(3'd4, 32'h12345678, 32'h0);
        checks++; if (hi !== 32'h12345678) begin fails++; $display("[TB] FAIL mthi_hi got %h want %h", hi, 32'h12345678); end
        checks++; if (lo !== 32'h0)        begin fails++; $display("[TB] FAIL mthi_lo got %h want %h", lo, 32'h0); end
        checks++; if (busy !== 1'b0)       begin fails++; $display("[TB] FAIL mthi_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0)       begin fails++; $display("[TB] FAIL mthi_done got %b want 0", done); end
        issue(3'd5, 32'hCAFEBABE, 32'h0);
        checks++; if (lo !== 32'hCAFEBABE) begin fails++; $display("[TB] FAIL mtlo_lo got %h want %h", lo, 32'hCAFEBABE); end
        checks++; if (hi !== 32'h12345678) begin fails++; $display("[TB] FAIL mtlo_hi got %h want %h", hi, 32'h12345678); end
        checks++; if (done !== 1'b0)       begin fails++; $display("[TB] FAIL mtlo_done got %b want 0", done); end
        // Reserved op codes leave everything alone
        issue(3'd6, 32'h0BADF00D, 32'h1);
        issue(3'd7, 32'h0BADF00D, 32'h1);
        checks++; if (hi !== 32'h12345678) begin fails++; $display("[TB] FAIL reserved_hi got %h want %h", hi, 32'h12345678); end
        checks++; if (lo !== 32'hCAFEBABE) begin fails++; $display("[TB] FAIL reserved_lo got %h want %h", lo, 32'hCAFEBABE); end
        checks++; if (busy !== 1'b0)       begin fails++; $display("[TB] FAIL reserved_busy got %b want 0", busy); end
    endtask

    task automatic test_multu_latency();
        int bad_busy;
        int bad_hold;
        bad_busy = 0;
        bad_hold = 0;
        issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        // Cycles 1..33: busy, no done, old HI/LO still visible
        for (int cyc = 1; cyc <= 33; cyc++) begin
            if (busy !== 1'b1 || done !== 1'b0) bad_busy++;
            if (hi !== 32'h12345678 || lo !== 32'hCAFEBABE) bad_hold++;
            step();
        end
        checks++; if (bad_busy !== 0) begin fails++; $display("[TB] FAIL multu_busy_window got %0d bad cycles want 0", bad_busy); end
        checks++; if (bad_hold !== 0) begin fails++; $display("[TB] FAIL multu_old_hilo got %0d bad cycles want 0", bad_hold); end
        // Cycle 34
        checks++; if (done !== 1'b1)       begin fails++; $display("[TB] FAIL multu_done34 got %b want 1", done); end
        checks++; if (busy !== 1'b0)       begin fails++; $display("[TB] FAIL multu_busy34 got %b want 0", busy); end
        checks++; if (hi !== 32'hFFFFFFFE) begin fails++; $display("[TB] FAIL multu_hi got %h want %h", hi, 32'hFFFFFFFE); end
        checks++; if (lo !== 32'h00000001) begin fails++; $display("[TB] FAIL multu_lo got %h want %h", lo, 32'h00000001); end
        step();
        checks++; if (done !== 1'b0)       begin fails++; $display("[TB] FAIL multu_done_pulse got %b want 0", done); end
    endtask

    task automatic test_mult();
        int cyc;
        issue(3'd0, 32'hFFFFFFFE, 32'h00000003);
        wait_done(1, cyc);
        checks++; if (cyc !== 34)          begin fails++; $display("[TB] FAIL mult_latency got %0d want 34", cyc); end
        checks++; if (hi !== 32'hFFFFFFFF) begin fails++; $display("[TB] FAIL mult_hi got %h want %h", hi, 32'hFFFFFFFF); end
        checks++; if (lo !== 32'hFFFFFFFA) begin fails++; $display("[TB] FAIL mult_lo got %h want %h", lo, 32'hFFFFFFFA); end
        step();
        // -65536 * -65536 = 2^32
        issue(3'd0, 32'hFFFF0000, 32'hFFFF0000);
        wait_done(1, cyc);
        checks++; if (hi !== 32'h00000001) begin fails++; $display("[TB] FAIL mult_negneg_hi got %h want %h", hi, 32'h1); end
        checks++; if (lo !== 32'h00000000) begin fails++; $display("[TB] FAIL mult_negneg_lo got %h want %h", lo, 32'h0); end
        step();
    endtask

    task automatic test_div();
        int cyc;
        issue(3'd2, 32'hFFFFFFF9, 32'h00000002);
        wait_done(1, cyc);
        checks++; if (cyc !== 34)          begin fails++; $display("[TB] FAIL div_latency got %0d want 34", cyc); end
        checks++; if (lo !== 32'hFFFFFFFD) begin fails++; $display("[TB] FAIL div_neg_lo got %h want %h", lo, 32'hFFFFFFFD); end
        checks++; if (hi !== 32'hFFFFFFFF) begin fails++; $display("[TB] FAIL div_neg_hi got %h want %h", hi, 32'hFFFFFFFF); end
        step();
        issue(3'd3, 32'd100, 32'd7);
        wait_done(1, cyc);
        checks++; if (lo !== 32'd14) begin fails++; $display("[TB] FAIL divu_lo got %h want %h", lo, 32'd14); end
        checks++; if (hi !== 32'd2)  begin fails++; $display("[TB] FAIL divu_hi got %h want %h", hi, 32'd2); end
        step();
        issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
        wait_done(1, cyc);
        checks++; if (lo !== 32'h80000000) begin fails++; $display("[TB] FAIL div_ovf_lo got %h want %h", lo, 32'h80000000); end
        checks++; if (hi !== 32'h0)        begin fails++; $display("[TB] FAIL div_ovf_hi got %h want %h", hi, 32'h0); end
        step();
        // 7 / -2 -> quotient -3, remainder +1
        issue(3'd2, 32'h00000007, 32'hFFFFFFFE);
        wait_done(1, cyc);
        checks++; if (lo !== 32'hFFFFFFFD) begin fails++; $display("[TB] FAIL div_posneg_lo got %h want %h", lo, 32'hFFFFFFFD); end
        checks++; if (hi !== 32'h00000001) begin fails++; $display("[TB] FAIL div_posneg_hi got %h want %h", hi, 32'h1); end
        step();
    endtask

    task automatic test_div_zero();
        int cyc;
        issue(3'd3, 32'h00000055, 32'h0);
        wait_done(1, cyc);
        checks++; if (cyc !== 34)          begin fails++; $display("[TB] FAIL divzero_latency got %0d want 34", cyc); end
        checks++; if (lo !== 32'hFFFFFFFF) begin fails++; $display("[TB] FAIL divzero_lo got %h want %h", lo, 32'hFFFFFFFF); end
        checks++; if (hi !== 32'h00000055) begin fails++; $display("[TB] FAIL divzero_hi got %h want %h", hi, 32'h55); end
        step();
    endtask

    task automatic test_back_to_back();
        int cyc;
        // HI/LO going in: hi=0x55, lo=0xFFFFFFFF
        issue(3'd1, 32'd3, 32'd5);
        step();
        start = 1'b1; op = 3'd4; a = 32'hDEADBEEF;
        step();
        start = 1'b0;
        checks++; if (hi !== 32'h00000055 || lo !== 32'hFFFFFFFF) begin fails++; $display("[TB] FAIL busy_mthi_ignored got hi=%h lo=%h want hi=%h lo=%h", hi, lo, 32'h55, 32'hFFFFFFFF); end
        start = 1'b1; op = 3'd2; a = 32'd100; b = 32'd7;
        step();
        start = 1'b0;
        checks++; if (hi !== 32'h00000055 || lo !== 32'hFFFFFFFF) begin fails++; $display("[TB] FAIL busy_div_ignored got hi=%h lo=%h want hi=%h lo=%h", hi, lo, 32'h55, 32'hFFFFFFFF); end
        wait_done(4, cyc);
        checks++; if (cyc !== 34)          begin fails++; $display("[TB] FAIL b2b_first_latency got %0d want 34", cyc); end
        checks++; if (hi !== 32'h0)        begin fails++; $display("[TB] FAIL b2b_first_hi got %h want %h", hi, 32'h0); end
        checks++; if (lo !== 32'd15)       begin fails++; $display("[TB] FAIL b2b_first_lo got %h want %h", lo, 32'd15); end
        // New operation issued in the done cycle
        issue(3'd3, 32'd9, 32'd4);
        checks++; if (busy !== 1'b1)       begin fails++; $display("[TB] FAIL b2b_accept_busy got %b want 1", busy); end
        wait_done(1, cyc);
        checks++; if (cyc !== 34)          begin fails++; $display("[TB] FAIL b2b_second_latency got %0d want 34", cyc); end
        checks++; if (lo !== 32'd2)        begin fails++; $display("[TB] FAIL b2b_second_lo got %h want %h", lo, 32'd2); end
        checks++; if (hi !== 32'd1)        begin fails++; $display("[TB] FAIL b2b_second_hi got %h want %h", hi, 32'd1); end
        step();
    endtask

    task automatic test_reset_midop();
        int seen_done;
        issue(3'd1, 32'd7, 32'd9);
        for (int cyc = 1; cyc < 10; cyc++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL midop_busy got %b want 0", busy); end
        checks++; if (hi !== 32'h0)  begin fails++; $display("[TB] FAIL midop_hi got %h want %h", hi, 32'h0); end
        checks++; if (lo !== 32'h0)  begin fails++; $display("[TB] FAIL midop_lo got %h want %h", lo, 32'h0); end
        seen_done = 0;
        for (int i = 0; i < 40; i++) begin
            if (done !== 1'b0 || lo !== 32'h0) seen_done++;
            step();
        end
        checks++; if (seen_done !== 0) begin fails++; $display("[TB] FAIL midop_no_result got %0d bad cycles want 0", seen_done); end
        // Simultaneous reset and start: reset wins
        issue(3'd4, 32'h11111111, 32'h0);
        rst = 1'b1; start = 1'b1; op = 3'd1; a = 32'd5; b = 32'd5;
        step();
        rst = 1'b0; start = 1'b0;
        checks++; if (hi !== 32'h0)  begin fails++; $display("[TB] FAIL rst_start_hi got %h want %h", hi, 32'h0); end
        checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL rst_start_busy got %b want 0", busy); end
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        rst    = 1'b1;
        start  = 1'b0;
        op     = 3'd0;
        a      = '0;
        b      = '0;
        test_reset();
        test_mt();
        test_multu_latency();
        test_mult();
        test_div();
        test_div_zero();
        test_back_to_back();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
